wt_multiplier_4x4: RTL and testbench
====================================

Name: wt_multiplier_4x4

Overview:
- Unsigned 4x4-bit multiplier built as a Wallace-tree reduction of partial products, followed by a final carry-propagate adder.
- The 8-bit product is registered, so the block drops into synchronous datapaths with one cycle of latency.
- Used as an arithmetic leaf cell; no handshake; a new operand pair is accepted every cycle.

Parameters:
- None. Widths are fixed: 4-bit operands, 8-bit product.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- A  input  4  unsigned multiplicand
- B  input  4  unsigned multiplier
- Product  output  8  registered unsigned product, A*B

Behaviour:
- Reset: while rst=1, Product=8'd0 immediately, with no clock required. Release of rst takes effect on the next rising clk edge.
- Latency: Product at edge N+1 equals A*B sampled at edge N. Throughput is one result per cycle. No input register is used: A and B feed the combinational tree directly.
- Arithmetic: unsigned throughout. Maximum result is 15*15=225, which fits in 8 bits, so the block has no overflow and no truncation.
- Partial products: pp[i][j] = A[j] & B[i], weight 2^(i+j). This gives 16 bits, with column heights 1,2,3,4,3,2,1 for weights 0..6.
- Reduction:
  - Reduce the columns in Wallace layers using explicit full adders (3:2) and half adders (2:2). In each layer, group every column greedily into FAs; leftover pairs go to an HA and singles pass through.
  - Repeat until every column holds at most 2 bits.
  - Carries move to weight+1.
- Final adder: a ripple-carry adder of the two remaining rows produces bits 0..7. Bit 7 is the final carry out.
- Use FA and HA as distinct submodules or functions. Do not use the behavioural `*` operator in the datapath.
- Mid-operation reset: asserting rst clears Product at once and discards the pending result. The first valid product after release appears one edge after the first post-release sampling edge.
- X handling: none required. Inputs are assumed known at each sampling edge.

Test Plan:
- Reset: assert rst with A=15, B=15 and clk toggling -> Product=0 throughout. Deassert rst -> 225 (8'b11100001) after the next edge.
- Sweep B=15, A=1..15, one per cycle -> Product sequence 15,30,45,...,210,225, each value one cycle after its operands.
- Sweep B=8, A=1..15 -> Product 8,16,24,...,112,120. This checks the single-bit multiplier path and the high-column carries.
- Zero and identity: A=0,B=13 -> 0; A=1,B=9 -> 9; A=7,B=1 -> 7; A=0,B=0 -> 0.
- Exhaustive: all 256 (A,B) pairs back-to-back -> Product equals A*B one cycle later, with no bubbles.
- Reset mid-stream: during the sweep, pulse rst asynchronously between edges -> Product=0 immediately. After release, correct products resume with 1-cycle latency.

Source files
------------

// File: rtl/wt_multiplier_4x4_if.sv
// ----------------------------------------------------------------------------
// wt_multiplier_4x4_if
//   Operand/result bundle for the 4x4 Wallace-tree multiplier.
//
//   Signals:
//     A        4-bit unsigned multiplicand
//     B        4-bit unsigned multiplier
//     Product  8-bit unsigned product, registered inside the multiplier
//
//   Modports:
//     master - the datapath feeding operands and consuming the product
//     slave  - the multiplier itself
// ----------------------------------------------------------------------------
interface wt_multiplier_4x4_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] Product;

  modport master (
    output A,
    output B,
    input  Product
  );

  modport slave (
    input  A,
    input  B,
    output Product
  );
endinterface : wt_multiplier_4x4_if

// File: rtl/wt_multiplier_4x4.sv
// ----------------------------------------------------------------------------
// wt_multiplier_4x4
//   Unsigned 4x4-bit multiplier. The sixteen partial products are reduced by
//   a two-layer Wallace tree of explicit full/half adders down to two rows,
//   which a ripple-carry adder then sums. The 8-bit product is registered,
//   giving one cycle of latency and one result per cycle. Operands are not
//   registered; they feed the tree combinationally.
//
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   asynchronous active-high reset, clears Product immediately
//     bus  slave modport of wt_multiplier_4x4_if
//            bus.A        in   4-bit multiplicand
//            bus.B        in   4-bit multiplier
//            bus.Product  out  8-bit registered product A*B
// ----------------------------------------------------------------------------
module wt_multiplier_4x4 (
  input  logic                  clk,
  input  logic                  rst,
  wt_multiplier_4x4_if.slave    bus
);

  // Sum/carry pair produced by one adder cell.
  typedef struct packed {
    logic c;
    logic s;
  } sum_t;

  // 3:2 compressor.
  function automatic sum_t fa(input logic x, input logic y, input logic z);
    sum_t r;
    r.s = x ^ y ^ z;
    r.c = (x & y) | (x & z) | (y & z);
    return r;
  endfunction

  // 2:2 compressor.
  function automatic sum_t ha(input logic x, input logic y);
    sum_t r;
    r.s = x ^ y;
    r.c = x & y;
    return r;
  endfunction

  // pp[i][j] = A[j] & B[i], weight 2^(i+j).
  logic [3:0][3:0] pp;

  // Layer 1 cells, named by the column weight they reduce.
  sum_t l1_h1, l1_f2, l1_f3, l1_f4, l1_h5;
  // Layer 2 cells.
  sum_t l2_h2, l2_f3, l2_h4, l2_h5, l2_h6;

  // The two rows left after reduction. Columns 0..2 and 7 hold a single bit,
  // so row_b only spans the weights where a second bit can exist.
  logic [7:0] row_a;
  logic [6:0] row_b;

  // Ripple-carry adder state: rc[k] is the carry into weight k.
  sum_t [6:0] rip;
  logic [7:0] rc;

  logic [7:0] product_d;
  logic [7:0] product_q;

  // NOTE: every variable assigned in always_comb gets a default at the top so
  // that no path leaves it unassigned and a latch can never be inferred.
  always_comb begin
    pp        = '0;
    l1_h1     = '0;
    l1_f2     = '0;
    l1_f3     = '0;
    l1_f4     = '0;
    l1_h5     = '0;
    l2_h2     = '0;
    l2_f3     = '0;
    l2_h4     = '0;
    l2_h5     = '0;
    l2_h6     = '0;
    row_a     = '0;
    row_b     = '0;
    rip       = '0;
    rc        = '0;
    product_d = '0;

    // Partial-product matrix; column heights 1,2,3,4,3,2,1 for weights 0..6.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = bus.A[j] & bus.B[i];
      end
    end

    // ---- Layer 1 -----------------------------------------------------------
    // w0 (1 bit)  : pp[0][0] passes through
    // w1 (2 bits) : HA
    // w2 (3 bits) : FA
    // w3 (4 bits) : FA on three bits, pp[3][0] passes through
    // w4 (3 bits) : FA
    // w5 (2 bits) : HA
    // w6 (1 bit)  : pp[3][3] passes through
    l1_h1 = ha(pp[0][1], pp[1][0]);
    l1_f2 = fa(pp[0][2], pp[1][1], pp[2][0]);
    l1_f3 = fa(pp[0][3], pp[1][2], pp[2][1]);
    l1_f4 = fa(pp[1][3], pp[2][2], pp[3][1]);
    l1_h5 = ha(pp[2][3], pp[3][2]);

    // ---- Layer 2 -----------------------------------------------------------
    // Heights entering this layer are 1,1,2,3,2,2,2 for weights 0..6; only
    // w3 still holds three bits, but every remaining pair is also compressed.
    l2_h2 = ha(l1_f2.s, l1_h1.c);
    l2_f3 = fa(l1_f3.s, pp[3][0], l1_f2.c);
    l2_h4 = ha(l1_f4.s, l1_f3.c);
    l2_h5 = ha(l1_h5.s, l1_f4.c);
    l2_h6 = ha(pp[3][3], l1_h5.c);

    // ---- Two-row form (every column now holds at most 2 bits) -------------
    row_a[0] = pp[0][0];
    row_a[1] = l1_h1.s;
    row_a[2] = l2_h2.s;
    row_a[3] = l2_f3.s;  row_b[3] = l2_h2.c;
    row_a[4] = l2_h4.s;  row_b[4] = l2_f3.c;
    row_a[5] = l2_h5.s;  row_b[5] = l2_h4.c;
    row_a[6] = l2_h6.s;  row_b[6] = l2_h5.c;
    row_a[7] = l2_h6.c;

    // ---- Final carry-propagate adder ---------------------------------------
    for (int k = 0; k < 7; k++) begin
      rip[k]       = fa(row_a[k], row_b[k], rc[k]);
      product_d[k] = rip[k].s;
      rc[k+1]      = rip[k].c;
    end
    // Weight 7 carries one tree bit plus the ripple carry. Since the largest
    // product is 225 the two are never both set, so a plain XOR yields bit 7
    // and the carry out of this column is always zero.
    product_d[7] = row_a[7] ^ rc[7];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_q <= '0;
    end else begin
      product_q <= product_d;
    end
  end

  assign bus.Product = product_q;

endmodule : wt_multiplier_4x4

// File: tb/tb_wt_multiplier_4x4.sv
// ----------------------------------------------------------------------------
// tb_wt_multiplier_4x4
//   Self-checking bench for wt_multiplier_4x4. Expected products come from
//   plain integer multiplication; the model tracks the value the output
//   register should hold after each edge (zero after reset).
// ----------------------------------------------------------------------------
module tb_wt_multiplier_4x4;

  logic clk;
  logic rst;

  wt_multiplier_4x4_if bus ();

  wt_multiplier_4x4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_prod;

  function automatic logic [7:0] ref_mul(input int a, input int b);
    return 8'(a * b);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called one time unit after a rising edge. Drives the operands, confirms
  // the register still holds the previous result before the next edge, then
  // confirms the new product one edge later.
  task automatic apply(input logic [3:0] a, input logic [3:0] b,
                       input string tag);
    bus.A = a;
    bus.B = b;
    #2;
    check($sformatf("%s_hold a=%0d b=%0d", tag, a, b), bus.Product, exp_prod);
    @(posedge clk);
    #1;
    exp_prod = ref_mul(a, b);
    check($sformatf("%s a=%0d b=%0d", tag, a, b), bus.Product, exp_prod);
  endtask

  // Watchdog: the stimulus is clock-counted, so this only fires if time
  // stops advancing toward the end of the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;

    // ---- Reset with maximal operands --------------------------------------
    rst   = 1'b1;
    bus.A = 4'd15;
    bus.B = 4'd15;
    #1;
    check("reset_async_t0", bus.Product, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", bus.Product, 8'd0);
    end
    rst      = 1'b0;
    exp_prod = 8'd0;
    #2;
    check("reset_release_no_edge", bus.Product, 8'd0);
    @(posedge clk);
    #1;
    exp_prod = ref_mul(15, 15);
    check("first_after_reset", bus.Product, exp_prod);

    // ---- Sweeps --------------------------------------------------------------
    for (int a = 1; a < 16; a++) apply(4'(a), 4'd15, "sweep_b15");
    for (int a = 1; a < 16; a++) apply(4'(a), 4'd8,  "sweep_b8");

    // ---- Zero and identity ---------------------------------------------------
    apply(4'd0, 4'd13, "zero_a");
    apply(4'd1, 4'd9,  "ident_a1");
    apply(4'd7, 4'd1,  "ident_b1");
    apply(4'd0, 4'd0,  "zero_both");

    // ---- Exhaustive, back-to-back -------------------------------------------
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply(4'(a), 4'(b), "exh");
      end
    end

    // ---- Random stream with asynchronous reset pulses -----------------------
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if (i % 50 == 25) begin
        // Pulse rst between edges: output clears with no clock, the
        // pending result is discarded, then operands sampled at the first
        // post-release edge appear right after it.
        bus.A = ra;
        bus.B = rb;
        #1;
        rst = 1'b1;
        #1;
        exp_prod = 8'd0;
        check("midstream_rst_async", bus.Product, exp_prod);
        #1;
        rst = 1'b0;
        #1;
        check("midstream_rst_released", bus.Product, exp_prod);
        @(posedge clk);
        #1;
        exp_prod = ref_mul(ra, rb);
        check($sformatf("midstream_resume a=%0d b=%0d", ra, rb),
              bus.Product, exp_prod);
      end else begin
        apply(ra, rb, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wt_multiplier_4x4
